// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM stage of a pipelined core. Issues one registered data
// memory request per load/store, stalls upstream until the one-cycle ack,
// aligns/extends load data and fills the MEM/WB register.
// Optional build macro: MEM_ALIGN_CHECK_EN (flag misaligned accesses instead of
// silently clearing the low address bits).
module mem_access_unit #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic                  RegWrite_i,
    input  logic                  MemtoReg_i,
    input  logic                  MemRead_i,
    input  logic                  MemWrite_i,
    input  logic [1:0]            size_i,
    input  logic                  unsigned_i,
    input  logic [DATA_W-1:0]     ALU_result_i,
    input  logic [DATA_W-1:0]     rt_data_i,
    input  logic [REG_W-1:0]      dest_reg_i,
    output logic                  stall_o,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [DATA_W-1:0]     dmem_addr_o,
    output logic [DATA_W/8-1:0]   dmem_be_o,
    output logic [DATA_W-1:0]     dmem_wdata_o,
    input  logic                  dmem_ack_i,
    input  logic [DATA_W-1:0]     dmem_rdata_i,
    output logic                  valid_o,
    output logic                  RegWrite_o,
    output logic                  MemtoReg_o,
    output logic [DATA_W-1:0]     read_data_o,
    output logic [DATA_W-1:0]     ALU_result_o,
    output logic [REG_W-1:0]      dest_reg_o,
    output logic                  misalign_o
);

    localparam int BE_W   = DATA_W / 8;
    localparam int LANE_W = $clog2(BE_W);
    localparam logic [DATA_W-1:0] LANE_MASK = DATA_W'(BE_W - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                state_reg, state_next;

    // request register
    logic                  req_reg, we_reg;
    logic [DATA_W-1:0]     addr_reg, wdata_reg;
    logic [BE_W-1:0]       be_reg;

    // access context kept for the completion cycle
    logic                  pend_load_reg, pend_unsigned_reg;
    logic                  pend_regwrite_reg, pend_memtoreg_reg;
    logic [3:0]            pend_bytes_reg;
    logic [LANE_W-1:0]     pend_lane_reg;
    logic [DATA_W-1:0]     pend_alu_reg;
    logic [REG_W-1:0]      pend_dest_reg;

    // MEM/WB register
    logic                  valid_reg, regwrite_reg, memtoreg_reg;
    logic [DATA_W-1:0]     read_data_reg, alu_reg;
    logic [REG_W-1:0]      dest_reg;

    // request-side datapath
    logic [1:0]            size_eff;
    logic [3:0]            size_bytes;
    logic [DATA_W-1:0]     size_off_mask;
    logic [DATA_W-1:0]     eff_addr;
    logic [LANE_W-1:0]     lane;
    logic [BE_W-1:0]       size_mask;
    logic [BE_W-1:0]       be_calc;
    logic [DATA_W-1:0]     wdata_calc;
    logic                  mem_op, misaligned;
    logic                  issue, complete;

    // load-side datapath
    logic [DATA_W-1:0]     load_shifted, load_top, load_data;
    logic [6:0]            ext_sh;

    // A dword access only exists on a 64-bit datapath; elsewhere it degrades to word
    always_comb begin
        size_eff = size_i;
        if (DATA_W == 32 && size_i == 2'b11)
            size_eff = 2'b10;
    end

    assign size_bytes    = 4'd1 << size_eff;
    assign size_off_mask = {{(DATA_W-4){1'b0}}, size_bytes - 4'd1};
    assign mem_op        = valid_i & (MemRead_i | MemWrite_i);

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = mem_op & (|(ALU_result_i & size_off_mask));
    assign eff_addr   = ALU_result_i;
`else
    assign misaligned = 1'b0;
    assign eff_addr   = ALU_result_i & ~size_off_mask;
`endif

    assign lane = eff_addr[LANE_W-1:0];

    // one enable bit per byte covered by the access size
    generate
        for (genvar gi = 0; gi < BE_W; gi++) begin : g_size_mask
            assign size_mask[gi] = (4'(gi) < size_bytes);
        end
    endgenerate

    assign be_calc = size_mask << lane;

    // Replicate the store datum into every lane so the memory just applies byte enables
    always_comb begin
        case (size_eff)
            2'b00:   wdata_calc = {BE_W{rt_data_i[7:0]}};
            2'b01:   wdata_calc = {(DATA_W/16){rt_data_i[15:0]}};
            2'b10:   wdata_calc = {(DATA_W/32){rt_data_i[31:0]}};
            default: wdata_calc = rt_data_i;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    // Next state, stall and issue/complete strobes
    always_comb begin
        state_next = state_reg;
        stall_o    = 1'b0;
        issue      = 1'b0;
        complete   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (mem_op && !misaligned) begin
                    stall_o    = 1'b1;
                    issue      = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                stall_o = !dmem_ack_i;
                if (dmem_ack_i) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request and access context: captured on issue, held stable while BUSY
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_reg           <= 1'b0;
            we_reg            <= 1'b0;
            addr_reg          <= '0;
            be_reg            <= '0;
            wdata_reg         <= '0;
            pend_load_reg     <= 1'b0;
            pend_unsigned_reg <= 1'b0;
            pend_regwrite_reg <= 1'b0;
            pend_memtoreg_reg <= 1'b0;
            pend_bytes_reg    <= 4'd1;
            pend_lane_reg     <= '0;
            pend_alu_reg      <= '0;
            pend_dest_reg     <= '0;
        end else if (issue) begin
            req_reg           <= 1'b1;
            we_reg            <= MemWrite_i;
            addr_reg          <= eff_addr & ~LANE_MASK;
            be_reg            <= be_calc;
            wdata_reg         <= wdata_calc;
            pend_load_reg     <= !MemWrite_i;
            pend_unsigned_reg <= unsigned_i;
            pend_regwrite_reg <= RegWrite_i;
            pend_memtoreg_reg <= MemtoReg_i;
            pend_bytes_reg    <= size_bytes;
            pend_lane_reg     <= lane;
            pend_alu_reg      <= ALU_result_i;
            pend_dest_reg     <= dest_reg_i;
        end else if (complete) begin
            req_reg <= 1'b0;
        end
    end

    // Shift the addressed bytes down, then sign/zero-extend by shifting up and back
    always_comb begin
        load_shifted = dmem_rdata_i >> {pend_lane_reg, 3'b000};
        ext_sh       = 7'(DATA_W) - {pend_bytes_reg, 3'b000};
        load_top     = load_shifted << ext_sh;
        if (pend_unsigned_reg)
            load_data = load_top >> ext_sh;
        else
            load_data = $unsigned($signed(load_top) >>> ext_sh);
    end

    // MEM/WB register: completion, pass-through, or bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_reg     <= 1'b0;
            regwrite_reg  <= 1'b0;
            memtoreg_reg  <= 1'b0;
            read_data_reg <= '0;
            alu_reg       <= '0;
            dest_reg      <= '0;
        end else if (complete) begin
            valid_reg     <= 1'b1;
            regwrite_reg  <= pend_regwrite_reg;
            memtoreg_reg  <= pend_memtoreg_reg;
            read_data_reg <= pend_load_reg ? load_data : '0;
            alu_reg       <= pend_alu_reg;
            dest_reg      <= pend_dest_reg;
        end else if (state_reg == IDLE && valid_i && !stall_o) begin
            // non-memory op, or a rejected misaligned access that must not write back
            valid_reg     <= 1'b1;
            regwrite_reg  <= RegWrite_i & ~misaligned;
            memtoreg_reg  <= MemtoReg_i;
            read_data_reg <= '0;
            alu_reg       <= ALU_result_i;
            dest_reg      <= dest_reg_i;
        end else begin
            valid_reg    <= 1'b0;
            regwrite_reg <= 1'b0;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic misalign_reg;

    // One-cycle flag that follows a rejected misaligned access
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) misalign_reg <= 1'b0;
        else      misalign_reg <= (state_reg == IDLE) && misaligned;
    end

    assign misalign_o = misalign_reg;
`else
    assign misalign_o = 1'b0;
`endif

    assign dmem_req_o   = req_reg;
    assign dmem_we_o    = we_reg;
    assign dmem_addr_o  = addr_reg;
    assign dmem_be_o    = be_reg;
    assign dmem_wdata_o = wdata_reg;
    assign valid_o      = valid_reg;
    assign RegWrite_o   = regwrite_reg;
    assign MemtoReg_o   = memtoreg_reg;
    assign read_data_o  = read_data_reg;
    assign ALU_result_o = alu_reg;
    assign dest_reg_o   = dest_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized
// loads/stores/ALU ops on a 32-bit instance and dword-capable 64-bit instance,
// compared against a byte-level reference model.
module tb_mem_access_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    int checks   = 0;
    int failures = 0;

    // 32-bit instance signals
    logic        valid_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, unsigned_i;
    logic [1:0]  size_i;
    logic [31:0] ALU_result_i, rt_data_i, dmem_rdata_i;
    logic [4:0]  dest_reg_i;
    logic        stall_o, dmem_req_o, dmem_we_o, dmem_ack_i;
    logic [31:0] dmem_addr_o, dmem_wdata_o, read_data_o, ALU_result_o;
    logic [3:0]  dmem_be_o;
    logic        valid_o, RegWrite_o, MemtoReg_o, misalign_o;
    logic [4:0]  dest_reg_o;

    // 64-bit instance signals
    logic        w_valid_i, w_RegWrite_i, w_MemtoReg_i, w_MemRead_i, w_MemWrite_i, w_unsigned_i;
    logic [1:0]  w_size_i;
    logic [63:0] w_ALU_result_i, w_rt_data_i, w_dmem_rdata_i;
    logic [4:0]  w_dest_reg_i;
    logic        w_stall_o, w_dmem_req_o, w_dmem_we_o, w_dmem_ack_i;
    logic [63:0] w_dmem_addr_o, w_dmem_wdata_o, w_read_data_o, w_ALU_result_o;
    logic [7:0]  w_dmem_be_o;
    logic        w_valid_o, w_RegWrite_o, w_MemtoReg_o, w_misalign_o;
    logic [4:0]  w_dest_reg_o;

    mem_access_unit #(.DATA_W(32), .REG_W(5)) dut32 (
        .clk(clk), .rst(rst), .valid_i(valid_i), .RegWrite_i(RegWrite_i),
        .MemtoReg_i(MemtoReg_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .size_i(size_i), .unsigned_i(unsigned_i), .ALU_result_i(ALU_result_i),
        .rt_data_i(rt_data_i), .dest_reg_i(dest_reg_i), .stall_o(stall_o),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i),
        .dmem_rdata_i(dmem_rdata_i), .valid_o(valid_o), .RegWrite_o(RegWrite_o),
        .MemtoReg_o(MemtoReg_o), .read_data_o(read_data_o), .ALU_result_o(ALU_result_o),
        .dest_reg_o(dest_reg_o), .misalign_o(misalign_o)
    );

    mem_access_unit #(.DATA_W(64), .REG_W(5)) dut64 (
        .clk(clk), .rst(rst), .valid_i(w_valid_i), .RegWrite_i(w_RegWrite_i),
        .MemtoReg_i(w_MemtoReg_i), .MemRead_i(w_MemRead_i), .MemWrite_i(w_MemWrite_i),
        .size_i(w_size_i), .unsigned_i(w_unsigned_i), .ALU_result_i(w_ALU_result_i),
        .rt_data_i(w_rt_data_i), .dest_reg_i(w_dest_reg_i), .stall_o(w_stall_o),
        .dmem_req_o(w_dmem_req_o), .dmem_we_o(w_dmem_we_o), .dmem_addr_o(w_dmem_addr_o),
        .dmem_be_o(w_dmem_be_o), .dmem_wdata_o(w_dmem_wdata_o), .dmem_ack_i(w_dmem_ack_i),
        .dmem_rdata_i(w_dmem_rdata_i), .valid_o(w_valid_o), .RegWrite_o(w_RegWrite_o),
        .MemtoReg_o(w_MemtoReg_o), .read_data_o(w_read_data_o), .ALU_result_o(w_ALU_result_o),
        .dest_reg_o(w_dest_reg_o), .misalign_o(w_misalign_o)
    );

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [1:0] sz, input int w);
        if (sz == 2'd3) return (w == 64) ? 8 : 4;
        return 1 << sz;
    endfunction

    function automatic logic [63:0] byte_mask(input int nb);
        if (nb == 8) return 64'hFFFF_FFFF_FFFF_FFFF;
        return (64'd1 << (8 * nb)) - 64'd1;
    endfunction

    function automatic int lane_of(input logic [63:0] a, input int nb, input int w);
        int off;
        off = int'(a[5:0]);
        off = off - (off % nb);
        return off % (w / 8);
    endfunction

    function automatic logic [63:0] exp_be(input int nb, input int lane);
        return 64'(((1 << nb) - 1) << lane);
    endfunction

    function automatic logic [63:0] exp_wdata(input logic [63:0] rt, input int nb, input int w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < w / (8 * nb); i++)
            r = r | ((rt & byte_mask(nb)) << (i * 8 * nb));
        return r;
    endfunction

    function automatic logic [63:0] exp_load(input logic [63:0] rd, input int lane, input int nb,
                                             input bit uns, input int w);
        logic [63:0] v;
        v = (rd >> (lane * 8)) & byte_mask(nb);
        if (!uns && v[8 * nb - 1]) v = v | ~byte_mask(nb);
        if (w == 32) v = v & 64'hFFFF_FFFF;
        return v;
    endfunction

    function automatic logic [63:0] exp_addr(input logic [63:0] a, input int w);
        return a & ~64'(w / 8 - 1);
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle32();
        valid_i = 0; MemRead_i = 0; MemWrite_i = 0; RegWrite_i = 0; MemtoReg_i = 0;
    endtask

    task automatic nonmem32(input bit rw, input bit m2r, input logic [31:0] a, input logic [4:0] dr);
        valid_i = 1; MemRead_i = 0; MemWrite_i = 0; RegWrite_i = rw; MemtoReg_i = m2r;
        ALU_result_i = a; dest_reg_i = dr; size_i = 2'($urandom_range(0, 3));
        @(negedge clk);
        chk("alu_stall", stall_o, 0);
        tick();
        idle32();
        chk("alu_valid", valid_o, 1);
        chk("alu_regwrite", RegWrite_o, rw);
        chk("alu_memtoreg", MemtoReg_o, m2r);
        chk("alu_result", ALU_result_o, a);
        chk("alu_dest", dest_reg_o, dr);
        chk("alu_noreq", dmem_req_o, 0);
        $display("ALU  a=%h dest=%0d valid_o=%0d", a, dr, valid_o);
    endtask

    task automatic bubble32(input bit ack);
        idle32();
        dmem_ack_i = ack;
        @(negedge clk);
        chk("bub_stall", stall_o, 0);
        tick();
        dmem_ack_i = 0;
        chk("bub_valid", valid_o, 0);
        chk("bub_regwrite", RegWrite_o, 0);
        chk("bub_noreq", dmem_req_o, 0);
        $display("BUB  ack=%0d valid_o=%0d", ack, valid_o);
    endtask

    task automatic mem_op32(input bit st, input logic [1:0] sz, input bit uns,
                            input logic [31:0] a, input logic [31:0] rt, input logic [31:0] rd,
                            input int waits, input bit rw, input bit m2r, input logic [4:0] dr,
                            output int stalls);
        int nb, ln;
        bit mis;
        logic [63:0] e_be, e_wd, e_ad;
        nb = nbytes(sz, 32);
        ln = lane_of({32'd0, a}, nb, 32);
`ifdef MEM_ALIGN_CHECK_EN
        mis = (int'(a[5:0]) % nb) != 0;
`else
        mis = 0;
`endif
        e_be = exp_be(nb, ln);
        e_wd = exp_wdata({32'd0, rt}, nb, 32);
        e_ad = exp_addr({32'd0, a & ~32'(nb - 1)}, 32);
        valid_i = 1; MemRead_i = !st; MemWrite_i = st; RegWrite_i = rw; MemtoReg_i = m2r;
        size_i = sz; unsigned_i = uns; ALU_result_i = a; rt_data_i = rt; dest_reg_i = dr;
        dmem_ack_i = 0;
        stalls = 0;
        if (mis) begin
            @(negedge clk);
            chk("mis_stall", stall_o, 0);
            tick();
            idle32();
            chk("mis_noreq", dmem_req_o, 0);
            chk("mis_valid", valid_o, 1);
            chk("mis_regwrite", RegWrite_o, 0);
            chk("mis_flag", misalign_o, 1);
            tick();
            chk("mis_flag_clear", misalign_o, 0);
            chk("mis_noreq2", dmem_req_o, 0);
            $display("MIS  st=%0d size=%0d a=%h", st, sz, a);
            return;
        end
        @(negedge clk);
        chk("issue_stall", stall_o, 1);
        stalls++;
        tick();
        chk("req", dmem_req_o, 1);
        chk("we", dmem_we_o, st);
        chk("addr", dmem_addr_o, e_ad);
        chk("be", dmem_be_o, e_be);
        chk("wdata", dmem_wdata_o, e_wd);
        chk("busy_bubble", valid_o, 0);
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            chk("busy_stall", stall_o, 1);
            stalls++;
            tick();
            chk("hold_req", dmem_req_o, 1);
            chk("hold_addr", dmem_addr_o, e_ad);
            chk("hold_be", dmem_be_o, e_be);
            chk("hold_wdata", dmem_wdata_o, e_wd);
            chk("hold_bubble", valid_o, 0);
        end
        dmem_ack_i = 1;
        dmem_rdata_i = rd;
        @(negedge clk);
        chk("ack_stall", stall_o, 0);
        tick();
        dmem_ack_i = 0;
        dmem_rdata_i = $urandom;
        idle32();
        chk("done_req", dmem_req_o, 0);
        chk("done_valid", valid_o, 1);
        chk("done_regwrite", RegWrite_o, rw);
        chk("done_memtoreg", MemtoReg_o, m2r);
        chk("done_dest", dest_reg_o, dr);
        chk("done_alu", ALU_result_o, a);
        chk("done_rdata", read_data_o, st ? 64'd0 : exp_load({32'd0, rd}, ln, nb, uns, 32));
        chk("done_misalign", misalign_o, 0);
        $display("MEM  st=%0d size=%0d uns=%0d a=%h be=%h wdata=%h rdata_o=%h stalls=%0d",
                 st, sz, uns, a, dmem_be_o, dmem_wdata_o, read_data_o, stalls);
    endtask

    task automatic mem_op64(input bit st, input logic [1:0] sz, input bit uns,
                            input logic [63:0] a, input logic [63:0] rt, input logic [63:0] rd);
        int nb, ln;
        nb = nbytes(sz, 64);
        ln = lane_of(a, nb, 64);
        w_valid_i = 1; w_MemRead_i = !st; w_MemWrite_i = st; w_RegWrite_i = 1; w_MemtoReg_i = !st;
        w_size_i = sz; w_unsigned_i = uns; w_ALU_result_i = a; w_rt_data_i = rt;
        w_dest_reg_i = 5'd9;
        @(negedge clk);
        chk("w_issue_stall", w_stall_o, 1);
        tick();
        chk("w_req", w_dmem_req_o, 1);
        chk("w_we", w_dmem_we_o, st);
        chk("w_addr", w_dmem_addr_o, exp_addr(a, 64));
        chk("w_be", w_dmem_be_o, exp_be(nb, ln));
        chk("w_wdata", w_dmem_wdata_o, exp_wdata(rt, nb, 64));
        w_dmem_ack_i = 1;
        w_dmem_rdata_i = rd;
        tick();
        w_dmem_ack_i = 0;
        w_valid_i = 0; w_MemRead_i = 0; w_MemWrite_i = 0;
        chk("w_valid", w_valid_o, 1);
        chk("w_rdata", w_read_data_o, st ? 64'd0 : exp_load(rd, ln, nb, uns, 64));
        $display("MEM64 st=%0d size=%0d uns=%0d a=%h be=%h rdata_o=%h", st, sz, uns, a,
                 w_dmem_be_o, w_read_data_o);
    endtask

    // ---------------- stimulus ----------------
    int          st_cnt, sel, nb;
    logic [31:0] ra, rrt, rrd;
    logic [63:0] wa, wrt, wrd;

    initial begin
        idle32();
        size_i = 0; unsigned_i = 0; ALU_result_i = 0; rt_data_i = 0; dest_reg_i = 0;
        dmem_ack_i = 0; dmem_rdata_i = 0;
        w_valid_i = 0; w_RegWrite_i = 0; w_MemtoReg_i = 0; w_MemRead_i = 0; w_MemWrite_i = 0;
        w_size_i = 0; w_unsigned_i = 0; w_ALU_result_i = 0; w_rt_data_i = 0; w_dest_reg_i = 0;
        w_dmem_ack_i = 0; w_dmem_rdata_i = 0;

        // asynchronous reset takes effect before any clock edge
        rst = 1;
        #2 rst = 0;
        #1;
        chk("rst_req", dmem_req_o, 0);
        chk("rst_we", dmem_we_o, 0);
        chk("rst_be", dmem_be_o, 0);
        chk("rst_addr", dmem_addr_o, 0);
        chk("rst_wdata", dmem_wdata_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_regwrite", RegWrite_o, 0);
        chk("rst_memtoreg", MemtoReg_o, 0);
        chk("rst_rdata", read_data_o, 0);
        chk("rst_alu", ALU_result_o, 0);
        chk("rst_dest", dest_reg_o, 0);
        chk("rst_misalign", misalign_o, 0);
        chk("rst_w_valid", w_valid_o, 0);
        $display("RST  req=%0d valid_o=%0d", dmem_req_o, valid_o);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1;
        tick();

        // signed byte load at top lane, immediate ack
        mem_op32(0, 2'b00, 0, 32'h103, 32'h0, 32'h8000_0000, 0, 1, 1, 5'd3, st_cnt);
        chk("r021_rdata", read_data_o, 32'hFFFF_FF80);
        chk("r021_stalls", st_cnt, 1);

        // half store, three BUSY cycles before ack
        mem_op32(1, 2'b01, 0, 32'h202, 32'h1234_ABCD, 32'h0, 3, 0, 0, 5'd0, st_cnt);
        chk("r022_stalls", st_cnt, 4);

        // ALU op followed directly by a load acked after two cycles
        nonmem32(1, 0, 32'hDEAD_0001, 5'd7);
        mem_op32(0, 2'b10, 1, 32'h40, 32'h0, 32'hCAFE_F00D, 1, 1, 1, 5'd8, st_cnt);
        chk("r023_rdata", read_data_o, 32'hCAFE_F00D);

        // ack while idle is ignored
        bubble32(1);
        bubble32(0);

        // reset in BUSY abandons the access; a late ack is ignored
        valid_i = 1; MemRead_i = 1; MemWrite_i = 0; RegWrite_i = 1; size_i = 2'b10;
        ALU_result_i = 32'h80; dest_reg_i = 5'd4;
        tick();
        chk("r024_busy_req", dmem_req_o, 1);
        #2 rst = 0;
        idle32();
        #1;
        chk("r024_req_drop", dmem_req_o, 0);
        chk("r024_valid", valid_o, 0);
        @(negedge clk);
        rst = 1;
        tick();
        dmem_ack_i = 1;
        dmem_rdata_i = 32'h5555_5555;
        tick();
        dmem_ack_i = 0;
        chk("r024_late_valid", valid_o, 0);
        chk("r024_late_req", dmem_req_o, 0);
        tick();
        chk("r024_late_valid2", valid_o, 0);
        $display("RST_BUSY req=%0d valid_o=%0d", dmem_req_o, valid_o);

`ifdef MEM_ALIGN_CHECK_EN
        // misaligned word load is rejected without touching memory
        mem_op32(0, 2'b10, 0, 32'h6, 32'h0, 32'h0, 0, 1, 1, 5'd2, st_cnt);
`endif

        // dword load on the 64-bit datapath
        wrd = {$urandom, $urandom};
        mem_op64(0, 2'b11, 1, 64'h8, 64'h0, wrd);
        chk("r026_rdata", w_read_data_o, wrd);
        chk("r026_be", w_dmem_be_o, 8'hFF);

        // randomized mix on the 32-bit instance
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 2) begin
                bubble32(1'($urandom_range(0, 1)));
            end else if (sel < 4) begin
                nonmem32(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                         5'($urandom_range(0, 31)));
            end else begin
                ra = $urandom; rrt = $urandom; rrd = $urandom;
                mem_op32(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                         1'($urandom_range(0, 1)), ra, rrt, rrd, $urandom_range(0, 3),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         5'($urandom_range(0, 31)), st_cnt);
            end
        end

        // randomized aligned accesses on the 64-bit instance
        for (int n = 0; n < 12; n++) begin
            sel = $urandom_range(0, 3);
            nb  = nbytes(2'(sel), 64);
            wa  = {$urandom, $urandom};
            wa  = wa & ~64'(nb - 1);
            wrt = {$urandom, $urandom};
            wrd = {$urandom, $urandom};
            mem_op64(1'($urandom_range(0, 1)), 2'(sel), 1'($urandom_range(0, 1)), wa, wrt, wrd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
- DATA_W, 32: data path width; legal values 32 or 64.
- REG_W, 5: destination register index width.
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- valid_i  in  1  EX/MEM slot holds an instruction.
- RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i  in  1 each  control from EX/MEM.
- size_i  in  2  access size: 00 byte, 01 half, 10 word, 11 dword (dword legal only when DATA_W=64, else treated as word).
- unsigned_i  in  1  load zero-extends when 1, sign-extends when 0.
- ALU_result_i  in  DATA_W  byte address or ALU value.
- rt_data_i  in  DATA_W  store data, right-aligned.
- dest_reg_i  in  REG_W  writeback register.
- stall_o  out  1  freeze IF..EX/MEM this cycle.
- dmem_req_o  out  1  memory request, registered.
- dmem_we_o  out  1  1 store, 0 load.
- dmem_addr_o  out  DATA_W  address with lane bits cleared.
- dmem_be_o  out  DATA_W/8  byte enables.
- dmem_wdata_o  out  DATA_W  lane-replicated store data.
- dmem_ack_i  in  1  one-cycle completion pulse.
- dmem_rdata_i  in  DATA_W  read data, valid with ack.
- valid_o, RegWrite_o, MemtoReg_o  out  1 each  MEM/WB register.
- read_data_o  out  DATA_W  extended load data.
- ALU_result_o  out  DATA_W  bypassed ALU value.
- dest_reg_o  out  REG_W  writeback register.
- misalign_o  out  1  registered misaligned-access flag.

Function
REQ-003 SHALL implement FSM states IDLE and BUSY.
REQ-004 IDLE, valid_i=1 with MemRead_i or MemWrite_i: stall_o=1 combinationally; at the edge, SHALL latch we/addr/be/wdata, set dmem_req_o=1, and go to BUSY.
REQ-005 BUSY: dmem_req_o and all dmem_* outputs SHALL stay stable; stall_o = !dmem_ack_i.
REQ-006 BUSY with dmem_ack_i=1: at the edge, SHALL load the MEM/WB register, clear dmem_req_o, and return to IDLE; stall_o=0 in that cycle, so upstream advances.
REQ-007 Memory-op latency SHALL be ack wait plus 2 cycles; minimum: op in IDLE at cycle 0, ack in cycle 1, valid_o=1 from cycle 2.
REQ-008 Non-memory instruction (valid_i=1, no MemRead_i/MemWrite_i) SHALL pass to MEM/WB with 1-cycle latency and no stall.
REQ-009 While stall_o=1, MEM/WB SHALL load a bubble: valid_o=0, RegWrite_o=0.
REQ-010 valid_i=0 SHALL load a bubble and SHALL NOT issue a request.
REQ-011 Lane = ALU_result_i[log2(DATA_W/8)-1:0]; dmem_be_o = size mask (1, 3, F, FF) shifted left by lane.
REQ-012 dmem_wdata_o SHALL replicate the low 8/16/32/64 bits of rt_data_i across the word.
REQ-013 Load data SHALL be dmem_rdata_i shifted right by lane*8, truncated to size, then sign- or zero-extended to DATA_W per unsigned_i.
REQ-014 Store completion SHALL produce valid_o=1 and RegWrite_o=RegWrite_i; read_data_o is don't-care and is driven 0.
REQ-015 dmem_ack_i in IDLE SHALL be ignored.
REQ-016 MEM/WB register fields SHALL hold their values only across bubbles; they are never gated by stall except per REQ-009.

Reset
REQ-017 rst=0 SHALL asynchronously force IDLE, dmem_req_o=0, dmem_we_o=0, dmem_be_o=0, dmem_addr_o=0, dmem_wdata_o=0, valid_o=0, RegWrite_o=0, MemtoReg_o=0, read_data_o=0, ALU_result_o=0, dest_reg_o=0, misalign_o=0.
REQ-018 Reset asserted in BUSY SHALL abandon the access; a later ack SHALL be ignored per REQ-015.

Configuration
REQ-019 Macro MEM_ALIGN_CHECK_EN defined: an access whose address is not size-aligned SHALL issue no request and no stall; the next cycle SHALL have valid_o=1, RegWrite_o=0, misalign_o=1 for one cycle.
REQ-020 Macro MEM_ALIGN_CHECK_EN undefined: misalign_o SHALL be tied 0; address bits below the access size SHALL be cleared before lane and byte-enable computation.

Verification
REQ-021 Load byte, DATA_W=32, addr 0x103, unsigned_i=0, rdata 0x80000000, ack at cycle 1 -> be=4'b1000, read_data_o=0xFFFFFF80, valid_o=1 at cycle 2.
REQ-022 Store half, addr 0x202, rt_data 0x1234ABCD, ack after 3 BUSY cycles -> be=4'b1100, wdata=0xABCDABCD, stall_o=1 for 4 cycles, request fields stable throughout.
REQ-023 Add followed by load with ack after 2 cycles -> add result at next cycle, then 2 bubbles (valid_o=0), then load result.
REQ-024 Reset pulsed in BUSY, ack arriving 1 cycle after release -> dmem_req_o=0 immediately, valid_o stays 0, ack ignored.
REQ-025 With MEM_ALIGN_CHECK_EN, load word at addr 0x6 -> dmem_req_o never 1, misalign_o=1 for one cycle, RegWrite_o=0.
REQ-026 DATA_W=64, dword load at addr 0x8 with unsigned_i=1 -> be=8'hFF, read_data_o=dmem_rdata_i.
